// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the stream_mux_n channel multiplexer.
package stream_mux_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/stream_mux_n_rr_pick.sv
// rr_pick: combinational round-robin search. Returns the first valid channel
// scanning ptr+1, ptr+2, ... modulo N.
module rr_pick
   import stream_mux_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned SW = $clog2(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [SW-1:0] ptr,
   output logic          found,
   output logic [SW-1:0] index
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;

   // Rotate the valid vector so bit 0 is channel ptr+1, then take the lowest set bit.
   always_comb begin
      dbl   = {valid, valid};
      rot   = N'(dbl >> (32'(ptr) + 32'd1));
      found = 1'b0;
      index = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            index = SW'((32'(ptr) + 32'd1 + i) % N);
         end
      end
   end

endmodule

// File: rtl/stream_mux_n.sv
// stream_mux_n: N-input packet-locked stream multiplexer with a registered
// output stage. Define STREAM_MUX_RR_EN to compile in round-robin mode;
// without it the block always uses the fixed select and ignores mode.
module stream_mux_n
   import stream_mux_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned W  = 8,
   parameter int unsigned SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_valid,
   input  logic [N-1:0]   in_last,
   output logic [N-1:0]   in_ready,
   input  logic [SW-1:0]  sel,
   input  logic           mode,
   output logic [W-1:0]   out_data,
   output logic           out_valid,
   output logic           out_last,
   output logic [SW-1:0]  out_chan,
   input  logic           out_ready
);

   state_t        state_q, state_d;
   logic [SW-1:0] grant_q, grant_d;
   logic          out_free;
   logic          fix_found;
   logic          cand_found;
   logic [SW-1:0] cand_idx;
   logic          take;
   logic          take_last;
   logic [W-1:0]  take_data;

   // Fixed-select candidate: sel must name an existing channel that is valid.
   always_comb begin
      fix_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (SW'(k) == sel && in_valid[k]) fix_found = 1'b1;
      end
   end

`ifdef STREAM_MUX_RR_EN
   logic [SW-1:0] ptr_q;
   logic          rr_found;
   logic [SW-1:0] rr_idx;

   rr_pick #(.N(N), .SW(SW)) u_rr_pick (
      .valid (in_valid),
      .ptr   (ptr_q),
      .found (rr_found),
      .index (rr_idx)
   );

   // Candidate choice; mode only matters while IDLE since it only feeds the grant.
   always_comb begin
      if (mode == MODE_RR) begin
         cand_found = rr_found;
         cand_idx   = rr_idx;
      end else begin
         cand_found = fix_found;
         cand_idx   = sel;
      end
   end

   // Round-robin pointer follows every grant; reset makes channel 0 first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= SW'(N - 1);
      end else if (state_q == IDLE && cand_found) begin
         ptr_q <= cand_idx;
      end
   end
`else
   logic unused_mode;
   assign unused_mode = mode;

   // Candidate choice: fixed select only.
   always_comb begin
      cand_found = fix_found;
      cand_idx   = sel;
   end
`endif

   // Controller state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end

   // Next state and per-channel ready; a granted channel is ready whenever the output slot frees.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      in_ready = '0;
      out_free = !out_valid || out_ready;
      unique case (state_q)
         IDLE: begin
            if (cand_found) begin
               state_d = LOCKED;
               grant_d = cand_idx;
            end
         end
         LOCKED: begin
            for (int k = 0; k < N; k++) begin
               if (SW'(k) == grant_q) begin
                  in_ready[k] = out_free;
                  if (out_free && in_valid[k] && in_last[k]) state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Select the accepted beat from the granted channel.
   always_comb begin
      take      = 1'b0;
      take_last = 1'b0;
      take_data = '0;
      for (int k = 0; k < N; k++) begin
         if (in_ready[k] && in_valid[k]) begin
            take      = 1'b1;
            take_last = in_last[k];
            take_data = in_data[k*W +: W];
         end
      end
   end

   // Output register: load on acceptance, hold under backpressure, drain on handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
      end else if (take) begin
         out_valid <= 1'b1;
         out_last  <= take_last;
         out_data  <= take_data;
         out_chan  <= grant_q;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_mux_n.sv
// Testbench for stream_mux_n: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a packet-level model.
module tb_stream_mux_n;

   localparam int unsigned N  = 4;
   localparam int unsigned W  = 8;
   localparam int unsigned SW = 2;
`ifdef STREAM_MUX_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Main N=4 instance
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid, in_last, in_ready;
   logic [SW-1:0]  sel, out_chan;
   logic           mode, out_valid, out_last, out_ready;
   logic [W-1:0]   out_data;

   stream_mux_n #(.N(N), .W(W)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .sel(sel), .mode(mode),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
      .out_chan(out_chan), .out_ready(out_ready));

   // N=8 instance
   logic [63:0] d8;
   logic [7:0]  v8, l8, ir8, od8;
   logic [2:0]  sel8, oc8;
   logic        mode8, ov8, ol8, ordy8;

   stream_mux_n #(.N(8), .W(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_data(d8), .in_valid(v8),
      .in_last(l8), .in_ready(ir8), .sel(sel8), .mode(mode8),
      .out_data(od8), .out_valid(ov8), .out_last(ol8),
      .out_chan(oc8), .out_ready(ordy8));

   // N=6 instance (select can exceed the channel count)
   logic [47:0] d6;
   logic [5:0]  v6, l6, ir6;
   logic [7:0]  od6;
   logic [2:0]  sel6, oc6;
   logic        mode6, ov6, ol6, ordy6;

   stream_mux_n #(.N(6), .W(8)) u_dut6 (
      .clk(clk), .rst_n(rst_n), .in_data(d6), .in_valid(v6),
      .in_last(l6), .in_ready(ir6), .sel(sel6), .mode(mode6),
      .out_data(od6), .out_valid(ov6), .out_last(ol6),
      .out_chan(oc6), .out_ready(ordy6));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model of the N=4 instance ----------------
   bit         m_locked;
   int         m_g, m_ptr, m_oc;
   bit         m_ov, m_ol;
   logic [7:0] m_od;

   function automatic logic [7:0] ch_data(input int ch);
      return in_data[ch*W +: W];
   endfunction

   // Which channel would be granted this cycle, or -1.
   function automatic int pick();
      if (RR_EN && mode) begin
         for (int i = 1; i <= N; i++) begin
            if (in_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
         end
      end else if (int'(sel) < N && in_valid[sel]) begin
         return int'(sel);
      end
      return -1;
   endfunction

   always @(negedge clk) begin : compare
      logic [N-1:0] exp_rdy;
      bit acc, was_locked;
      int c;
      if (!rst_n) begin
         m_locked = 0; m_g = 0; m_ptr = N - 1; m_ov = 0; m_ol = 0; m_od = 0; m_oc = 0;
         check("rst in_ready", 32'(in_ready), 0);
         check("rst out_valid", 32'(out_valid), 0);
         check("rst out_data", 32'(out_data), 0);
         check("rst out_last", 32'(out_last), 0);
         check("rst out_chan", 32'(out_chan), 0);
      end else begin
         exp_rdy = '0;
         if (m_locked && (!m_ov || out_ready)) exp_rdy[m_g] = 1'b1;
         check("model in_ready", 32'(in_ready), 32'(exp_rdy));
         check("model out_valid", 32'(out_valid), 32'(m_ov));
         if (m_ov) begin
            check("model out_data", 32'(out_data), 32'(m_od));
            check("model out_last", 32'(out_last), 32'(m_ol));
            check("model out_chan", 32'(out_chan), 32'(m_oc));
         end
         was_locked = m_locked;
         acc = m_locked && in_valid[m_g] && (!m_ov || out_ready);
         if (acc) begin
            m_ov = 1; m_od = ch_data(m_g); m_ol = in_last[m_g]; m_oc = m_g;
            if (in_last[m_g]) m_locked = 0;
         end else if (out_ready) begin
            m_ov = 0;
         end
         if (!was_locked) begin
            c = pick();
            if (c >= 0) begin
               m_locked = 1; m_g = c; m_ptr = c;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_ch(input int k, input logic [7:0] d, input logic l);
      in_data[k*W +: W] = d;
      in_last[k] = l;
   endtask

   task automatic idle_inputs();
      in_data = '0; in_valid = '0; in_last = '0; sel = '0; mode = 1'b0; out_ready = 1'b1;
      d8 = '0; v8 = '0; l8 = '0; sel8 = '0; mode8 = 1'b0; ordy8 = 1'b1;
      d6 = '0; v6 = '0; l6 = '0; sel6 = '0; mode6 = 1'b0; ordy6 = 1'b1;
   endtask

   task automatic do_reset();
      idle_inputs();
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   int beat_chan[5];
   int beat_cyc[5];
   int nb;
   int exp_chan[5];

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Fixed select, two-beat packet on channel 2.
      do_reset();
      mode = 1'b0; sel = 2'd2; out_ready = 1'b1; in_valid = 4'b0100; set_ch(2, 8'h11, 1'b0);
      @(negedge clk); check("t1 idle ready", 32'(in_ready), 0);
      @(posedge clk);
      @(negedge clk); check("t1 locked ready", 32'(in_ready), 32'h4);
      @(posedge clk); #1;
      check("t1 b1 valid", 32'(out_valid), 1);
      check("t1 b1 data", 32'(out_data), 32'h11);
      check("t1 b1 last", 32'(out_last), 0);
      check("t1 b1 chan", 32'(out_chan), 2);
      set_ch(2, 8'h22, 1'b1);
      @(negedge clk); check("t1 b2 ready", 32'(in_ready), 32'h4);
      @(posedge clk); #1;
      check("t1 b2 data", 32'(out_data), 32'h22);
      check("t1 b2 last", 32'(out_last), 1);
      check("t1 b2 chan", 32'(out_chan), 2);
      in_valid = '0;
      @(negedge clk); check("t1 after ready", 32'(in_ready), 0);

      // Backpressure on a three-beat packet from channel 1.
      do_reset();
      mode = 1'b0; sel = 2'd1; out_ready = 1'b1; in_valid = 4'b0010; set_ch(1, 8'hA1, 1'b0);
      @(posedge clk);
      @(posedge clk); #1;
      check("t2 b1 data", 32'(out_data), 32'hA1);
      out_ready = 1'b0; set_ch(1, 8'hB2, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t2 stall ready", 32'(in_ready), 0);
         check("t2 stall valid", 32'(out_valid), 1);
         check("t2 stall data", 32'(out_data), 32'hA1);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1;
      check("t2 b2 data", 32'(out_data), 32'hB2);
      check("t2 b2 valid", 32'(out_valid), 1);
      set_ch(1, 8'hC3, 1'b1);
      @(posedge clk); #1;
      check("t2 b3 data", 32'(out_data), 32'hC3);
      check("t2 b3 last", 32'(out_last), 1);
      in_valid = '0;

      // All channels valid with single-beat packets, mode=1, sel=1.
      do_reset();
`ifdef STREAM_MUX_RR_EN
      exp_chan = '{0, 1, 2, 3, 0};
`else
      exp_chan = '{1, 1, 1, 1, 1};
`endif
      mode = 1'b1; sel = 2'd1; out_ready = 1'b1; in_valid = 4'hF; in_last = 4'hF;
      for (int k = 0; k < N; k++) set_ch(k, 8'(8'hC0 + k), 1'b1);
      nb = 0;
      for (int c = 0; c < 40 && nb < 5; c++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            beat_chan[nb] = int'(out_chan);
            beat_cyc[nb] = c;
            nb++;
         end
      end
      check("t3 beat count", 32'(nb), 5);
      for (int i = 0; i < nb; i++) begin
         check("t3 chan", 32'(beat_chan[i]), 32'(exp_chan[i]));
         if (i > 0) check("t3 spacing", 32'(beat_cyc[i] - beat_cyc[i-1]), 2);
      end
      in_valid = '0;

      // Reset mid-packet on channel 3, then restart.
      do_reset();
      mode = 1'b0; sel = 2'd3; out_ready = 1'b1; in_valid = 4'b1000; set_ch(3, 8'h31, 1'b0);
      @(posedge clk);
      @(posedge clk); #1;
      check("t4 b1 valid", 32'(out_valid), 1);
      set_ch(3, 8'h32, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("t4 async valid", 32'(out_valid), 0);
      check("t4 async ready", 32'(in_ready), 0);
      check("t4 async data", 32'(out_data), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      mode = 1'b1; sel = 2'd0; in_valid = 4'hF; in_last = 4'hF;
      nb = 0;
      for (int c = 0; c < 10 && nb == 0; c++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            beat_chan[0] = int'(out_chan);
            nb = 1;
         end
      end
      check("t4 restart seen", 32'(nb), 1);
      check("t4 restart chan", 32'(beat_chan[0]), 0);

      // N=8: sel=5 grant; mid-packet sel change ignored until last.
      do_reset();
      for (int k = 0; k < 8; k++) d8[k*8 +: 8] = 8'(8'h50 + k);
      mode8 = 1'b0; sel8 = 3'd5; ordy8 = 1'b1; v8 = 8'hFF; l8 = 8'h00;
      @(posedge clk);
      @(posedge clk); #1;
      check("t5 chan", 32'(oc8), 5);
      check("t5 data", 32'(od8), 32'h55);
      sel8 = 3'd2;
      @(posedge clk); #1; check("t5 hold chan a", 32'(oc8), 5);
      @(posedge clk); #1; check("t5 hold chan b", 32'(oc8), 5);
      l8 = 8'hFF;
      @(posedge clk); #1;
      check("t5 last chan", 32'(oc8), 5);
      check("t5 last flag", 32'(ol8), 1);
      @(posedge clk); #1; check("t5 gap", 32'(ov8), 0);
      @(posedge clk); #1;
      check("t5 new chan", 32'(oc8), 2);
      check("t5 new data", 32'(od8), 32'h52);
      v8 = '0;

      // N=6: sel=7 never grants.
      do_reset();
      mode6 = 1'b0; sel6 = 3'd7; ordy6 = 1'b1; v6 = 6'h3F; l6 = 6'h3F;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("t6 ready", 32'(ir6), 0);
         check("t6 valid", 32'(ov6), 0);
      end
      v6 = '0;

      // Randomized traffic on the main instance.
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int k = 0; k < N; k++) begin
            in_valid[k] = ($urandom_range(0, 9) < 7);
            in_last[k]  = ($urandom_range(0, 9) < 3);
            in_data[k*W +: W] = 8'($urandom);
         end
         sel = 2'($urandom_range(0, 3));
         mode = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 499) == 0) begin
            #2 rst_n = 1'b0;
            @(posedge clk); #1 rst_n = 1'b1;
         end
         @(posedge clk); #1;
      end

      idle_inputs();
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
